fibonacci_control: RTL and testbench

//  Control FSM for the fibonacci datapath: accepts a start/N request, drives the seed, init and

---
 rtl/fibonacci_control.sv | 140 ++++++++++++++
 tb/tb_fibonacci_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_control.sv
// Control FSM for the fibonacci datapath: sequences seed load and iteration,
// captures F(N), and reports done/busy, adder overflow and watchdog aborts.
module fibonacci_control #(
  parameter int W        = 8,
  parameter int MAX_ITER = 255
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [W-1:0] i_n_req,
  input  logic         i_cmp_gt,
  input  logic         i_sum_carry,
  input  logic [W-1:0] i_fib_value,
  output logic         o_dp_init,
  output logic         o_dp_n1,
  output logic         o_dp_n2,
  output logic         o_dp_n3,
  output logic [W-1:0] o_dp_n,
  output logic         o_en_reg1,
  output logic         o_en_reg2,
  output logic         o_en_regn,
  output logic         o_en_count,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_overflow,
  output logic         o_error
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [W-1:0]    r_n_q;
  logic [IW-1:0]   r_iter;
  logic [W-1:0]    r_result;
  logic            r_overflow;
  logic            r_error;
  logic            w_dp_en;
  logic            w_wd_hit;

  // Watchdog fires only while the datapath still wants to iterate.
  assign w_wd_hit = (r_state == S_RUN) && i_cmp_gt && (r_iter == ITER_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next_state = S_INIT;
      S_INIT: w_next_state = S_RUN;
      S_RUN:  if (!i_cmp_gt || w_wd_hit) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_dp_init = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    w_dp_en   = 1'b0;
    case (r_state)
      S_INIT: begin
        o_dp_init = 1'b1;
        o_busy    = 1'b1;
        w_dp_en   = 1'b1;
      end
      S_RUN: begin
        o_busy  = 1'b1;
        w_dp_en = i_cmp_gt && !w_wd_hit;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_n_q      <= '0;
      r_iter     <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_n_q      <= i_n_req;
            r_iter     <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_wd_hit) begin
            r_error <= 1'b1;
          end else if (i_cmp_gt) begin
            r_iter     <= r_iter + 1'b1;
            r_overflow <= r_overflow | i_sum_carry;
          end else begin
            r_result <= i_fib_value;
          end
        end
        default: ;
      endcase
    end
  end

  // Seeds F(0)=0, F(1)=1, count=0 are only meaningful during the load cycle.
  assign o_dp_n1    = 1'b0;
  assign o_dp_n2    = o_dp_init;
  assign o_dp_n3    = 1'b0;
  assign o_dp_n     = r_n_q;
  assign o_en_reg1  = w_dp_en;
  assign o_en_reg2  = w_dp_en;
  assign o_en_regn  = w_dp_en;
  assign o_en_count = w_dp_en;
  assign o_result   = r_result;
  assign o_overflow = r_overflow;
  assign o_error    = r_error;

endmodule

// File: tb/tb_fibonacci_control.sv
// Directed bench for fibonacci_control: a small fibonacci datapath model closes
// the loop around one DUT; a second DUT with MAX_ITER=20 exercises the watchdog.
module tb_fibonacci_control;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_a, start_b;
  logic [W-1:0] n_req_a, n_req_b;

  // Datapath model state
  logic [W-1:0] m_reg1, m_reg2, m_count, m_regf;
  logic [W:0]   m_sum;
  logic         cmp_gt, sum_carry;

  logic         dp_init_a, n1_a, n2_a, n3_a, busy_a, done_a, ovf_a, err_a;
  logic         e1_a, e2_a, en_a, ec_a;
  logic [W-1:0] dp_n_a, result_a;

  logic         dp_init_b, n1_b, n2_b, n3_b, busy_b, done_b, ovf_b, err_b;
  logic         e1_b, e2_b, en_b, ec_b;
  logic [W-1:0] dp_n_b, result_b;

  int n_checks = 0;
  int n_errors = 0;
  logic sel;

  always #5 clk = ~clk;

  fibonacci_control #(.W(W), .MAX_ITER(255)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_n_req(n_req_a),
    .i_cmp_gt(cmp_gt), .i_sum_carry(sum_carry), .i_fib_value(m_reg1),
    .o_dp_init(dp_init_a), .o_dp_n1(n1_a), .o_dp_n2(n2_a), .o_dp_n3(n3_a),
    .o_dp_n(dp_n_a), .o_en_reg1(e1_a), .o_en_reg2(e2_a), .o_en_regn(en_a),
    .o_en_count(ec_a), .o_busy(busy_a), .o_done(done_a), .o_result(result_a),
    .o_overflow(ovf_a), .o_error(err_a)
  );

  fibonacci_control #(.W(W), .MAX_ITER(20)) u_dut_wd (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_n_req(n_req_b),
    .i_cmp_gt(1'b1), .i_sum_carry(1'b0), .i_fib_value(8'hAA),
    .o_dp_init(dp_init_b), .o_dp_n1(n1_b), .o_dp_n2(n2_b), .o_dp_n3(n3_b),
    .o_dp_n(dp_n_b), .o_en_reg1(e1_b), .o_en_reg2(e2_b), .o_en_regn(en_b),
    .o_en_count(ec_b), .o_busy(busy_b), .o_done(done_b), .o_result(result_b),
    .o_overflow(ovf_b), .o_error(err_b)
  );

  // Fibonacci datapath: reg1=F(count), reg2=F(count+1), regf=N
  assign m_sum     = {1'b0, m_reg1} + {1'b0, m_reg2};
  assign sum_carry = m_sum[W];
  assign cmp_gt    = m_regf > m_count;

  always @(posedge clk) begin
    if (rst) begin
      m_reg1 <= '0; m_reg2 <= '0; m_count <= '0; m_regf <= '0;
    end else begin
      if (e1_a) m_reg1 <= dp_init_a ? {{(W-1){1'b0}}, n1_a} : m_reg2;
      if (e2_a) m_reg2 <= dp_init_a ? {{(W-1){1'b0}}, n2_a} : m_sum[W-1:0];
      if (ec_a) m_count <= dp_init_a ? {{(W-1){1'b0}}, n3_a} : m_count + 1'b1;
      if (en_a) m_regf <= dp_n_a;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] outs_a();
    return {4'd0, dp_init_a, n1_a, n2_a, n3_a, dp_n_a, e1_a, e2_a, en_a, ec_a,
            busy_a, done_a, result_a, ovf_a, err_a};
  endfunction

  // Issue one start on the selected DUT and watch until done (bounded).
  task automatic run(input logic [W-1:0] n, output int lat, output int en_cnt,
                     output int busy_cnt, output int split_cnt, output logic [3:0] seeds);
    logic d, b, e1, e2, en, ec;
    @(negedge clk);
    if (sel) begin start_b = 1'b1; n_req_b = n; end
    else     begin start_a = 1'b1; n_req_a = n; end
    @(posedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
    lat = 0; en_cnt = 0; busy_cnt = 0; split_cnt = 0; seeds = '0;
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      d  = sel ? done_b : done_a;
      b  = sel ? busy_b : busy_a;
      e1 = sel ? e1_b : e1_a;  e2 = sel ? e2_b : e2_a;
      en = sel ? en_b : en_a;  ec = sel ? ec_b : ec_a;
      if (t == 1) seeds = sel ? {dp_init_b, n1_b, n2_b, n3_b} : {dp_init_a, n1_a, n2_a, n3_a};
      if (b) busy_cnt++;
      if (e1 && e2 && en && ec) en_cnt++;
      if ((e1 | e2 | en | ec) && !(e1 & e2 & en & ec)) split_cnt++;
      if (d) begin
        lat = t;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int lat, en_cnt, busy_cnt, split_cnt;
  logic [3:0] seeds;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; n_req_a = '0; n_req_b = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs_a(), 32'd0);
    check("reset_outputs_wd", {dp_init_b, busy_b, done_b, e1_b, result_b, ovf_b, err_b}, 32'd0);

    // 1: N=0
    run(8'd0, lat, en_cnt, busy_cnt, split_cnt, seeds);
    check("n0_latency", lat, 3);
    check("n0_busy_cycles", busy_cnt, 2);
    check("n0_en_cycles", en_cnt, 1);
    check("n0_result", result_a, 0);
    check("n0_flags", {ovf_a, err_a}, 0);

    // 2: N=10
    run(8'd10, lat, en_cnt, busy_cnt, split_cnt, seeds);
    check("n10_seeds", seeds, 4'b1010);
    check("n10_latency", lat, 13);
    check("n10_en_cycles", en_cnt, 11);
    check("n10_busy_cycles", busy_cnt, 12);
    check("n10_result", result_a, 55);
    check("n10_flags", {ovf_a, err_a}, 0);
    check("n10_split", split_cnt, 0);
    @(negedge clk);
    check("done_one_pulse", {done_a, busy_a, e1_a}, 0);
    check("result_held", result_a, 55);

    // 3: N=13 then N=1 back-to-back
    run(8'd13, lat, en_cnt, busy_cnt, split_cnt, seeds);
    check("n13_latency", lat, 16);
    check("n13_result", result_a, 233);
    run(8'd1, lat, en_cnt, busy_cnt, split_cnt, seeds);
    check("n1_latency", lat, 4);
    check("n1_result", result_a, 1);
    check("n1_overflow_cleared", ovf_a, 0);

    // 4: N=14 overflows the 8-bit adder
    run(8'd14, lat, en_cnt, busy_cnt, split_cnt, seeds);
    check("n14_overflow", ovf_a, 1);
    check("n14_result", result_a, 121);
    check("n14_error", err_a, 0);

    // 5: watchdog on the MAX_ITER=20 instance
    sel = 1'b1;
    run(8'd5, lat, en_cnt, busy_cnt, split_cnt, seeds);
    check("wd_latency", lat, 23);
    check("wd_en_cycles", en_cnt, 21);
    check("wd_error", err_b, 1);
    check("wd_result_unchanged", result_b, 0);
    @(negedge clk);
    check("wd_error_held", {err_b, done_b}, 2'b10);
    sel = 1'b0;

    // 6: start ignored while busy, then reset mid-run
    @(negedge clk);
    start_a = 1'b1; n_req_a = 8'd50;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (5) @(negedge clk);
    start_a = 1'b1; n_req_a = 8'd7;
    @(negedge clk);
    start_a = 1'b0;
    check("busy_start_ignored", dp_n_a, 50);
    check("midrun_busy_en", {busy_a, e1_a}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", outs_a(), 32'd0);

    // Simultaneous reset and start: reset wins
    start_a = 1'b1; n_req_a = 8'd3;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    @(negedge clk);
    check("reset_beats_start", {busy_a, dp_init_a, dp_n_a}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
